// File: rtl/multi_port_circ_q.sv
// Multi-lane circular queue: up to ENQ_W pushes and DEQ_W pops per cycle, with occupancy, almost-full and flush.
// Optional sticky overflow/underflow flags are compiled in with `define MULTI_PORT_CIRC_Q_ERR_EN.
module multi_port_circ_q #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int ENQ_W    = 2,
    parameter int DEQ_W    = 2,
    parameter int AFULL_TH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [$clog2(ENQ_W+1)-1:0]   enq_cnt,
    input  logic [ENQ_W*WIDTH-1:0]       enq_data,
    output logic                         enq_ok,
    input  logic [$clog2(DEQ_W+1)-1:0]   deq_cnt,
    output logic [DEQ_W*WIDTH-1:0]       out_data,
    output logic [DEQ_W-1:0]             out_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH+1)-1:0]   free_slots,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full
`ifdef MULTI_PORT_CIRC_Q_ERR_EN
    ,
    output logic                         err_ovf,
    output logic                         err_udf
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = $clog2(ENQ_W + 1);
    localparam logic [31:0] AFULL_TH_U = AFULL_TH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    deq_eff;
    logic [CW-1:0]    enq_acc;
    logic [ENQ_W-1:0] lane_we;

    // Handshake: the producer offers enq_cnt entries; they are taken on the clock edge
    // only when enq_ok is high, otherwise the producer holds them. Pops never stall.
    always_comb begin
        free_slots  = CW'(DEPTH) - count_q;
        enq_ok      = !flush && (CW'(enq_cnt) <= free_slots);
        count       = count_q;
        empty       = (count_q == '0);
        full        = (count_q == CW'(DEPTH));
        almost_full = (32'(free_slots) <= AFULL_TH_U);
    end

    always_comb begin
        deq_eff = (CW'(deq_cnt) > count_q) ? count_q : CW'(deq_cnt);
        enq_acc = enq_ok ? CW'(enq_cnt) : '0;
        lane_we = '0;
        for (int i = 0; i < ENQ_W; i++) begin
            lane_we[i] = enq_ok && (EW'(i) < enq_cnt);
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(deq_eff);
            tail_d  = tail_q + PW'(enq_acc);
            count_d = count_q + enq_acc - deq_eff;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left unreset; out_valid gating hides stale contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_W; i++) begin
            if (lane_we[i]) begin
                mem_q[tail_q + PW'(i)] <= enq_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_data  = '0;
        out_valid = '0;
        for (int i = 0; i < DEQ_W; i++) begin
            out_valid[i] = (CW'(i) < count_q);
            if (out_valid[i]) begin
                out_data[i*WIDTH +: WIDTH] = mem_q[head_q + PW'(i)];
            end
        end
    end

`ifdef MULTI_PORT_CIRC_Q_ERR_EN
    logic err_ovf_q, err_ovf_d;
    logic err_udf_q, err_udf_d;

    always_comb begin
        if (flush) begin
            err_ovf_d = 1'b0;
            err_udf_d = 1'b0;
        end else begin
            err_ovf_d = err_ovf_q || ((enq_cnt != '0) && !enq_ok);
            err_udf_d = err_udf_q || (CW'(deq_cnt) > count_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;
`endif

endmodule

// File: tb/tb_multi_port_circ_q.sv
// Directed bench for multi_port_circ_q with default parameters (WIDTH=32, DEPTH=8, 2+2 lanes, AFULL_TH=2).
module tb_multi_port_circ_q;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush;
    logic [1:0]      enq_cnt;
    logic [2*W-1:0]  enq_data;
    logic            enq_ok;
    logic [1:0]      deq_cnt;
    logic [2*W-1:0]  out_data;
    logic [1:0]      out_valid;
    logic [3:0]      count;
    logic [3:0]      free_slots;
    logic            empty;
    logic            full;
    logic            almost_full;
`ifdef MULTI_PORT_CIRC_Q_ERR_EN
    logic            err_ovf;
    logic            err_udf;
`endif

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    multi_port_circ_q dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .enq_cnt     (enq_cnt),
        .enq_data    (enq_data),
        .enq_ok      (enq_ok),
        .deq_cnt     (deq_cnt),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .count       (count),
        .free_slots  (free_slots),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full)
`ifdef MULTI_PORT_CIRC_Q_ERR_EN
        ,
        .err_ovf     (err_ovf),
        .err_udf     (err_udf)
`endif
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Driver tasks
    task automatic drive(input logic [1:0] ec, input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [1:0] dc, input logic fl);
        enq_cnt  = ec;
        enq_data = {d1, d0};
        deq_cnt  = dc;
        flush    = fl;
    endtask

    task automatic idle();
        drive(2'd0, '0, '0, 2'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
        checks++; if (free_slots !== 4'd8) begin errors++; $display("FAIL reset_free: got %0d expected 8", free_slots); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull: got %0b expected 0", almost_full); end
        checks++; if (enq_ok !== 1'b1) begin errors++; $display("FAIL reset_enq_ok: got %0b expected 1", enq_ok); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %0b expected 00", out_valid); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %0h expected 0", out_data); end
`ifdef MULTI_PORT_CIRC_Q_ERR_EN
        checks++; if ({err_ovf, err_udf} !== 2'b00) begin errors++; $display("FAIL reset_err: got %0b expected 00", {err_ovf, err_udf}); end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        for (int k = 0; k < 3; k++) begin
            drive(2'd2, W'(32'h10 + 2*k), W'(32'h11 + 2*k), 2'd0, 1'b0);
            #1;
            checks++; if (enq_ok !== 1'b1) begin errors++; $display("FAIL fill_enq_ok[%0d]: got %0b expected 1", k, enq_ok); end
            tick();
        end
        idle();
        #1;
        checks++; if (count !== 4'd6) begin errors++; $display("FAIL fill_count: got %0d expected 6", count); end
        checks++; if (free_slots !== 4'd2) begin errors++; $display("FAIL fill_free: got %0d expected 2", free_slots); end
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL fill_afull: got %0b expected 1", almost_full); end
        checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL fill_valid: got %0b expected 11", out_valid); end
        checks++; if (out_data !== {32'h11, 32'h10}) begin errors++; $display("FAIL fill_data: got %0h expected 0000001100000010", out_data); end
    endtask

    task automatic test_overflow();
        drive(2'd1, 32'h16, '0, 2'd0, 1'b0);
        tick();
        drive(2'd2, 32'hEE, 32'hEF, 2'd0, 1'b0);
        #1;
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL ovf_count7: got %0d expected 7", count); end
        checks++; if (enq_ok !== 1'b0) begin errors++; $display("FAIL ovf_enq_ok: got %0b expected 0", enq_ok); end
        tick();
        idle();
        #1;
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL ovf_count_hold: got %0d expected 7", count); end
        checks++; if (out_data[W-1:0] !== 32'h10) begin errors++; $display("FAIL ovf_no_write: got %0h expected 10", out_data[W-1:0]); end
`ifdef MULTI_PORT_CIRC_Q_ERR_EN
        checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_err: got %0b expected 1", err_ovf); end
`endif
        drive(2'd1, 32'h17, '0, 2'd0, 1'b0);
        tick();
        drive(2'd1, 32'h99, '0, 2'd0, 1'b0);
        #1;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %0b expected 1", full); end
        checks++; if (free_slots !== 4'd0) begin errors++; $display("FAIL full_free: got %0d expected 0", free_slots); end
        checks++; if (enq_ok !== 1'b0) begin errors++; $display("FAIL full_enq_ok: got %0b expected 0", enq_ok); end
        for (int k = 0; k < 4; k++) begin
            drive(2'd0, '0, '0, 2'd2, 1'b0);
            #1;
            checks++; if (out_data !== {W'(32'h11 + 2*k), W'(32'h10 + 2*k)}) begin
                errors++; $display("FAIL drain_data[%0d]: got %0h expected %0h", k, out_data, {W'(32'h11 + 2*k), W'(32'h10 + 2*k)});
            end
            tick();
        end
        idle();
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_dual();
        drive(2'd1, 32'h1F, '0, 2'd0, 1'b0);
        tick();
        drive(2'd2, 32'h20, 32'h21, 2'd2, 1'b0);
        #1;
        checks++; if (enq_ok !== 1'b1) begin errors++; $display("FAIL dual_enq_ok: got %0b expected 1", enq_ok); end
        checks++; if (out_valid !== 2'b01) begin errors++; $display("FAIL dual_valid_pre: got %0b expected 01", out_valid); end
        checks++; if (out_data !== {32'h0, 32'h1F}) begin errors++; $display("FAIL dual_data_pre: got %0h expected 1f", out_data); end
        tick();
        idle();
        #1;
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL dual_count: got %0d expected 2", count); end
        checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL dual_valid: got %0b expected 11", out_valid); end
        checks++; if (out_data !== {32'h21, 32'h20}) begin errors++; $display("FAIL dual_data: got %0h expected 0000002100000020", out_data); end
`ifdef MULTI_PORT_CIRC_Q_ERR_EN
        checks++; if (err_udf !== 1'b1) begin errors++; $display("FAIL dual_err_udf: got %0b expected 1", err_udf); end
`endif
        drive(2'd0, '0, '0, 2'd2, 1'b0);
        tick();
        idle();
    endtask

    task automatic test_flush();
        drive(2'd2, 32'h40, 32'h41, 2'd0, 1'b0);
        tick();
        drive(2'd2, 32'h42, 32'h43, 2'd0, 1'b0);
        tick();
        drive(2'd1, 32'h44, '0, 2'd0, 1'b0);
        tick();
        drive(2'd2, 32'h98, 32'h9A, 2'd1, 1'b1);
        #1;
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre_count: got %0d expected 5", count); end
        checks++; if (enq_ok !== 1'b0) begin errors++; $display("FAIL flush_enq_ok: got %0b expected 0", enq_ok); end
        tick();
        idle();
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %0b expected 1", empty); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL flush_valid: got %0b expected 00", out_valid); end
        checks++; if (free_slots !== 4'd8) begin errors++; $display("FAIL flush_free: got %0d expected 8", free_slots); end
`ifdef MULTI_PORT_CIRC_Q_ERR_EN
        checks++; if ({err_ovf, err_udf} !== 2'b00) begin errors++; $display("FAIL flush_err: got %0b expected 00", {err_ovf, err_udf}); end
`endif
        drive(2'd1, 32'h55, '0, 2'd0, 1'b0);
        tick();
        idle();
        #1;
        checks++; if (out_data !== {32'h0, 32'h55}) begin errors++; $display("FAIL flush_after_data: got %0h expected 55", out_data); end
        drive(2'd0, '0, '0, 2'd1, 1'b0);
        tick();
        idle();
    endtask

    task automatic test_wrap();
        drive(2'd0, '0, '0, 2'd0, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(2'd2, W'(32'h60 + 2*k), W'(32'h61 + 2*k), 2'd2, 1'b0);
            tick();
        end
        drive(2'd0, '0, '0, 2'd2, 1'b0);
        tick();
        drive(2'd2, 32'hA, 32'hB, 2'd0, 1'b0);
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_start_empty: got %0b expected 1", empty); end
        tick();
        drive(2'd2, 32'hC, 32'hD, 2'd0, 1'b0);
        #1;
        checks++; if (out_data !== {32'hB, 32'hA}) begin errors++; $display("FAIL wrap_ab: got %0h expected 0000000b0000000a", out_data); end
        checks++; if (enq_ok !== 1'b1) begin errors++; $display("FAIL wrap_enq_ok: got %0b expected 1", enq_ok); end
        tick();
        drive(2'd0, '0, '0, 2'd2, 1'b0);
        #1;
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL wrap_count: got %0d expected 4", count); end
        checks++; if (out_data !== {32'hB, 32'hA}) begin errors++; $display("FAIL wrap_pop1: got %0h expected 0000000b0000000a", out_data); end
        tick();
        #1;
        checks++; if (out_data !== {32'hD, 32'hC}) begin errors++; $display("FAIL wrap_pop2: got %0h expected 0000000d0000000c", out_data); end
        tick();
        idle();
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_end_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_back_to_back();
        int deqs[6] = '{0, 1, 2, 2, 1, 2};
        logic [W-1:0] v;
        int pops;
        logic exp_ok;
        v = 32'h100;
        exp_q.delete();
        for (int c = 0; c < 6; c++) begin
            drive(2'd2, v, v + 1, 2'(deqs[c]), 1'b0);
            #1;
            exp_ok = ((8 - exp_q.size()) >= 2);
            checks++; if (enq_ok !== exp_ok) begin errors++; $display("FAIL b2b_enq_ok[%0d]: got %0b expected %0b", c, enq_ok, exp_ok); end
            for (int l = 0; l < 2; l++) begin
                checks++;
                if (out_valid[l] !== (l < exp_q.size())) begin
                    errors++; $display("FAIL b2b_valid[%0d][%0d]: got %0b expected %0b", c, l, out_valid[l], (l < exp_q.size()));
                end else if (l < exp_q.size() && out_data[l*W +: W] !== exp_q[l]) begin
                    errors++; $display("FAIL b2b_data[%0d][%0d]: got %0h expected %0h", c, l, out_data[l*W +: W], exp_q[l]);
                end
            end
            tick();
            pops = (deqs[c] < exp_q.size()) ? deqs[c] : exp_q.size();
            for (int p = 0; p < pops; p++) void'(exp_q.pop_front());
            if (exp_ok) begin
                exp_q.push_back(v);
                exp_q.push_back(v + 1);
            end
            v = v + 2;
        end
        idle();
        #1;
        checks++; if (32'(count) !== exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", count, exp_q.size()); end
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) begin
            drive(2'd0, '0, '0, 2'd1, 1'b0);
            #1;
            checks++; if (out_data[W-1:0] !== exp_q[0]) begin errors++; $display("FAIL b2b_drain[%0d]: got %0h expected %0h", k, out_data[W-1:0], exp_q[0]); end
            tick();
            void'(exp_q.pop_front());
        end
        drive(2'd0, '0, '0, 2'd2, 1'b0);
        tick();
        idle();
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_async_reset();
        drive(2'd2, 32'h70, 32'h71, 2'd0, 1'b0);
        tick();
        drive(2'd2, 32'h72, 32'h73, 2'd0, 1'b0);
        tick();
        idle();
        #1;
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL areset_pre_count: got %0d expected 4", count); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL areset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL areset_empty: got %0b expected 1", empty); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL areset_valid: got %0b expected 00", out_valid); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        idle();
        test_reset();
        test_fill();
        test_overflow();
        test_dual();
        test_flush();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
